// File: rtl/mon_sense_sequencer_if.sv
// Request/status bundle between the monitor-enable logic and the shared-ADC sense sequencer.
interface mon_sense_sequencer_if #(
  parameter int N_CH  = 4,
  parameter int TMO_W = 16,
  parameter int PER_W = 16
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]  EN_sync;
  logic             MODE_PER;
  logic [PER_W-1:0] PERIOD;
  logic [TMO_W-1:0] TIMEOUT;
  logic             DONE;
  logic             mon_run;
  logic [CW-1:0]    ch_sel;
  logic             conv_valid;
  logic             timeout_err;
  logic [CW-1:0]    conv_ch;
  logic             busy;

  modport master (
    output EN_sync, MODE_PER, PERIOD, TIMEOUT, DONE,
    input  mon_run, ch_sel, conv_valid, timeout_err, conv_ch, busy
  );

  modport slave (
    input  EN_sync, MODE_PER, PERIOD, TIMEOUT, DONE,
    output mon_run, ch_sel, conv_valid, timeout_err, conv_ch, busy
  );
endinterface

// File: rtl/mon_sense_sequencer.sv
// Round-robin arbiter that time-shares one ADC between N_CH monitor channels,
// running each conversion until synchronised DONE, timeout or enable drop.
module mon_sense_sequencer #(
  parameter int N_CH    = 4,
  parameter int TMO_W   = 16,
  parameter int PER_W   = 16,
  parameter int GAP_CYC = 2
) (
  input  logic                  HF_CLK,
  input  logic                  RST_sync,
  mon_sense_sequencer_if.slave  bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             done_s;
  logic [N_CH-1:0]  en_prev_q;
  logic [N_CH-1:0]  pending_q, pending_d, clr_mask;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             per_wrap;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             armed_q, armed_d;
  logic [CW-1:0]    ch_sel_q, ch_sel_d;
  logic [CW-1:0]    last_q, last_d;
  logic [CW-1:0]    conv_ch_q, conv_ch_d;
  logic [CW-1:0]    winner;
  logic             mon_run_q, mon_run_d;
  logic             conv_valid_q, conv_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             any_pend, gap_last, launch;
  logic             run_done, run_abort, run_tmo;

  assign done_s    = sync_q[1];
  assign any_pend  = |pending_q;
  assign gap_last  = (gap_cnt_q == GW'(GAP_CYC - 1));
  assign launch    = any_pend && ((state_q == IDLE) || ((state_q == GAP) && gap_last));
  assign run_done  = armed_q && done_s;
  assign run_abort = !bus.EN_sync[ch_sel_q];
  assign run_tmo   = (bus.TIMEOUT != '0) && (tmo_cnt_q == bus.TIMEOUT - TMO_W'(1));

  always_comb begin
    per_cnt_d = '0;
    per_wrap  = 1'b0;
    if (bus.MODE_PER && (bus.PERIOD != '0)) begin
      if (per_cnt_q >= bus.PERIOD - PER_W'(1)) per_wrap  = 1'b1;
      else                                     per_cnt_d = per_cnt_q + PER_W'(1);
    end
  end

  // New requests are applied after the completion clear so a same-cycle set survives.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | (bus.EN_sync & ~en_prev_q);
    if (per_wrap) pending_d = pending_d | bus.EN_sync;
    pending_d = pending_d & bus.EN_sync;
  end

  // Lowest pending index overall, overridden by the lowest one strictly above last_q.
  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pending_q[i]) winner = CW'(i);
    for (int i = N_CH - 1; i >= 0; i--)
      if (pending_q[i] && (CW'(i) > last_q)) winner = CW'(i);
  end

  always_ff @(posedge HF_CLK or posedge RST_sync) begin
    if (RST_sync) begin
      sync_q    <= '0;
      en_prev_q <= '0;
      pending_q <= '0;
      per_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], bus.DONE};
      en_prev_q <= bus.EN_sync;
      pending_q <= pending_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  always_ff @(posedge HF_CLK or posedge RST_sync) begin
    if (RST_sync) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      armed_q       <= 1'b0;
      ch_sel_q      <= '0;
      last_q        <= CW'(N_CH - 1);
      conv_ch_q     <= '0;
      mon_run_q     <= 1'b0;
      conv_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      armed_q       <= armed_d;
      ch_sel_q      <= ch_sel_d;
      last_q        <= last_d;
      conv_ch_q     <= conv_ch_d;
      mon_run_q     <= mon_run_d;
      conv_valid_q  <= conv_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // GAP can launch straight into RUN so mon_run stays low for exactly GAP_CYC cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (run_done || run_abort || run_tmo) state_d = GAP;
      GAP:     if (gap_last) state_d = launch ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_sel_d      = ch_sel_q;
    last_d        = last_q;
    conv_ch_d     = conv_ch_q;
    conv_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    clr_mask      = '0;
    tmo_cnt_d     = tmo_cnt_q;
    armed_d       = armed_q;
    gap_cnt_d     = '0;
    mon_run_d     = (state_d == RUN);
    case (state_q)
      RUN: begin
        armed_d = armed_q | ~done_s;
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (run_done) begin
          conv_valid_d       = 1'b1;
          conv_ch_d          = ch_sel_q;
          clr_mask[ch_sel_q] = 1'b1;
        end else if (run_abort) begin
          clr_mask[ch_sel_q] = 1'b1;
        end else if (run_tmo) begin
          timeout_err_d      = 1'b1;
          conv_ch_d          = ch_sel_q;
          clr_mask[ch_sel_q] = 1'b1;
        end
      end
      GAP:     gap_cnt_d = gap_cnt_q + GW'(1);
      default: ;
    endcase
    if (launch) begin
      ch_sel_d  = winner;
      last_d    = winner;
      tmo_cnt_d = '0;
      armed_d   = 1'b0;
    end
  end

  assign bus.mon_run     = mon_run_q;
  assign bus.ch_sel      = ch_sel_q;
  assign bus.conv_valid  = conv_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.conv_ch     = conv_ch_q;
  assign bus.busy        = (state_q != IDLE) || any_pend;
endmodule
